ahb_top: RTL and testbench

AHB_TOP -- requirements
Module: ahb_top

---
 rtl/ahb_if.sv | 22 ++
 rtl/ahb_top.sv | 211 +++++++++++++++++++++
 tb/tb_ahb_top.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/ahb_if.sv
// AHB-Lite bus between the load/store master and the slave fabric inside ahb_top.
// Every slave runs with zero wait states, so only OKAY responses and HREADY=1 are ever returned.
interface ahb_if;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [31:0] hwdata;
  logic [31:0] hrdata;
  logic        hready;
  logic        hresp;

  modport master (
    output haddr, htrans, hwrite, hsize, hwdata,
    input  hrdata, hready, hresp
  );

  modport slave (
    input  haddr, htrans, hwrite, hsize, hwdata,
    output hrdata, hready, hresp
  );
endinterface

// File: rtl/ahb_top.sv
// Load/store unit: an AHB-Lite master feeds a decoder with ROM, RAM and default slaves.
// Accesses are fully pipelined. The address phase is combinational from the inputs, and data_out is valid two edges later.
module ahb_master (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_write,
  input  logic        mem_read,
  input  logic [2:0]  func3,
  input  logic [31:0] rs2_data,
  input  logic [31:0] alu_out,
  input  logic [31:0] address,
  ahb_if.master       bus,
  output logic [31:0] data_out
);
  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [2:0] HSIZE_WORD    = 3'b010;
  localparam logic       HRESP_OKAY    = 1'b0;

  logic        is_data;
  logic        dp_active;
  logic        dp_write;
  logic [2:0]  dp_func3;
  logic [1:0]  dp_lane;
  logic [31:0] wdata_q;

  function automatic logic [31:0] replicate(input logic [1:0] size, input logic [31:0] d);
    case (size)
      2'b00:   return {4{d[7:0]}};
      2'b01:   return {2{d[15:0]}};
      default: return d;
    endcase
  endfunction

  function automatic logic [31:0] format_load(input logic [2:0] f3, input logic [1:0] lane,
                                              input logic [31:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    b = 8'(w >> {lane, 3'b000});
    h = lane[1] ? w[31:16] : w[15:0];
    case (f3)
      3'b000:  return {{24{b[7]}}, b};
      3'b100:  return {24'h0, b};
      3'b001:  return {{16{h[15]}}, h};
      3'b101:  return {16'h0, h};
      default: return w;
    endcase
  endfunction

  // NOTE: every output gets its default first, so no path through the block can infer a latch.
  always_comb begin
    is_data     = mem_read | mem_write;
    bus.haddr   = is_data ? alu_out : address;
    bus.hwrite  = mem_write;
    bus.htrans  = reset ? HTRANS_IDLE : HTRANS_NONSEQ;
    bus.hsize   = HSIZE_WORD;
    if (is_data && func3[1:0] != 2'b11) bus.hsize = {1'b0, func3[1:0]};
    bus.hwdata  = wdata_q;
  end

  // NOTE: state registers use non-blocking assignments, so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      dp_active <= 1'b0;
      dp_write  <= 1'b0;
      dp_func3  <= HSIZE_WORD;
      dp_lane   <= 2'b00;
      wdata_q   <= '0;
      data_out  <= '0;
    end else begin
      dp_active <= (bus.htrans == HTRANS_NONSEQ);
      dp_write  <= bus.hwrite;
      dp_func3  <= is_data ? func3 : 3'b010;
      dp_lane   <= bus.haddr[1:0];
      wdata_q   <= replicate(func3[1:0], rs2_data);
      if (dp_active && !dp_write && bus.hready && bus.hresp == HRESP_OKAY)
        data_out <= format_load(dp_func3, dp_lane, bus.hrdata);
    end
  end
endmodule

module ahb_fabric #(
  parameter int ROM_WORDS = 256,
  parameter int RAM_WORDS = 256
) (
  input  logic  clk,
  input  logic  reset,
  ahb_if.slave  bus
);
  localparam int ROM_AW = $clog2(ROM_WORDS);
  localparam int RAM_AW = $clog2(RAM_WORDS);
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  typedef enum logic [1:0] {SEL_DEFAULT, SEL_ROM, SEL_RAM} sel_t;

  sel_t              ap_sel, dp_sel;
  logic              ap_active;
  logic [ROM_AW-1:0] ap_rom_idx;
  logic [RAM_AW-1:0] ap_ram_idx, dp_ram_idx;
  logic              dp_write;
  logic [2:0]        dp_size;
  logic [1:0]        dp_lane;
  logic [3:0]        dp_strb;
  logic              ram_we;
  logic [31:0]       ram_wword;
  logic [31:0]       rom_q, ram_q;
  logic [31:0]       ram_mem [RAM_WORDS];

  always_comb begin
    ap_sel = SEL_DEFAULT;
    case (bus.haddr[31:28])
      4'hA:    ap_sel = SEL_ROM;
      4'hB:    ap_sel = SEL_RAM;
      default: ap_sel = SEL_DEFAULT;
    endcase
    ap_active  = (bus.htrans == HTRANS_NONSEQ);
    ap_rom_idx = bus.haddr[2 +: ROM_AW];
    ap_ram_idx = bus.haddr[2 +: RAM_AW];

    case (dp_size)
      3'b000:  dp_strb = 4'b0001 << dp_lane;
      3'b001:  dp_strb = dp_lane[1] ? 4'b1100 : 4'b0011;
      default: dp_strb = 4'b1111;
    endcase
    ram_we    = dp_write && dp_sel == SEL_RAM;
    ram_wword = ram_mem[dp_ram_idx];
    for (int i = 0; i < 4; i++)
      if (dp_strb[i]) ram_wword[8*i +: 8] = bus.hwdata[8*i +: 8];

    bus.hready = 1'b1;
    bus.hresp  = 1'b0;
    case (dp_sel)
      SEL_ROM: bus.hrdata = rom_q;
      SEL_RAM: bus.hrdata = ram_q;
      default: bus.hrdata = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      dp_sel     <= SEL_DEFAULT;
      dp_write   <= 1'b0;
      dp_size    <= 3'b010;
      dp_lane    <= 2'b00;
      dp_ram_idx <= '0;
    end else begin
      dp_sel     <= ap_active ? ap_sel : SEL_DEFAULT;
      dp_write   <= ap_active && bus.hwrite;
      dp_size    <= bus.hsize;
      dp_lane    <= bus.haddr[1:0];
      dp_ram_idx <= ap_ram_idx;
    end
  end

  // ROM: constant contents, so only the read register needs a reset value.
  always_ff @(posedge clk) begin
    if (reset)
      rom_q <= '0;
    else if (ap_active && ap_sel == SEL_ROM && !bus.hwrite)
      rom_q <= {8'hA5, 16'h0000, 8'(ap_rom_idx)};
  end

  // RAM: a read colliding with the write completing this edge sees the merged word.
  // NOTE: the array is cleared on reset, so it maps to flops rather than a RAM macro.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < RAM_WORDS; i++) ram_mem[i] <= '0;
      ram_q <= '0;
    end else begin
      if (ram_we) ram_mem[dp_ram_idx] <= ram_wword;
      if (ap_active && ap_sel == SEL_RAM && !bus.hwrite)
        ram_q <= (ram_we && dp_ram_idx == ap_ram_idx) ? ram_wword : ram_mem[ap_ram_idx];
    end
  end
endmodule

module ahb_top #(
  parameter int ROM_WORDS = 256,
  parameter int RAM_WORDS = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_write,
  input  logic        mem_read,
  input  logic [2:0]  func3,
  input  logic [31:0] rs2_data,
  input  logic [31:0] alu_out,
  input  logic [31:0] address,
  output logic [31:0] data_out
);
  ahb_if bus ();

  ahb_master u_master (
    .clk       (clk),
    .reset     (reset),
    .mem_write (mem_write),
    .mem_read  (mem_read),
    .func3     (func3),
    .rs2_data  (rs2_data),
    .alu_out   (alu_out),
    .address   (address),
    .bus       (bus),
    .data_out  (data_out)
  );

  ahb_fabric #(.ROM_WORDS(ROM_WORDS), .RAM_WORDS(RAM_WORDS)) u_fabric (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );
endmodule

// File: tb/tb_ahb_top.sv
// Bench for ahb_top: a directed vector table, hand-written reset sequences, and random traffic.
// A byte-addressed memory model processes accesses in program order.
module tb_ahb_top;
  logic        clk = 1'b0;
  logic        reset;
  logic        mem_write, mem_read;
  logic [2:0]  func3;
  logic [31:0] rs2_data, alu_out, address;
  logic [31:0] data_out;

  always #5 clk = ~clk;

  ahb_top dut (
    .clk       (clk),
    .reset     (reset),
    .mem_write (mem_write),
    .mem_read  (mem_read),
    .func3     (func3),
    .rs2_data  (rs2_data),
    .alu_out   (alu_out),
    .address   (address),
    .data_out  (data_out)
  );

  typedef struct {
    logic        valid;
    logic        rd;
    logic        wr;
    logic [2:0]  f3;
    logic [31:0] rs2;
    logic [31:0] alu;
    logic [31:0] addr;
    logic        has_exp;
    logic [31:0] exp;
    int          id;
  } acc_t;

  logic [7:0]  ram_b [1024];
  logic [31:0] exp_cur;
  acc_t        prev, landed;
  int          passed = 0;
  int          total  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: data_out=%h expected=%h", name, act, exp);
  endtask

  function automatic acc_t mk(input logic rd, input logic wr, input logic [2:0] f3,
                              input logic [31:0] rs2, input logic [31:0] alu,
                              input logic [31:0] addr, input logic has_exp,
                              input logic [31:0] exp, input int id);
    acc_t a;
    a.valid = 1'b1; a.rd = rd; a.wr = wr; a.f3 = f3; a.rs2 = rs2; a.alu = alu;
    a.addr = addr; a.has_exp = has_exp; a.exp = exp; a.id = id;
    return a;
  endfunction

  function automatic acc_t fetch(input logic [31:0] addr);
    return mk(1'b0, 1'b0, 3'b010, 32'h0, 32'h0, addr, 1'b0, 32'h0, -1);
  endfunction

  function automatic logic [31:0] read_word(input logic [31:0] a);
    int base;
    base = int'(a[9:2]) * 4;
    case (a[31:28])
      4'hA:    return {8'hA5, 16'h0000, a[9:2]};
      4'hB:    return {ram_b[base+3], ram_b[base+2], ram_b[base+1], ram_b[base]};
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] model_load(input acc_t a);
    logic [31:0] w;
    logic [7:0]  b;
    logic [15:0] h;
    if (!(a.rd || a.wr)) return read_word(a.addr);
    w = read_word(a.alu);
    b = 8'(w >> (8 * int'(a.alu[1:0])));
    h = a.alu[1] ? w[31:16] : w[15:0];
    case (a.f3)
      3'b000:  return {{24{b[7]}}, b};
      3'b100:  return {24'h0, b};
      3'b001:  return {{16{h[15]}}, h};
      3'b101:  return {16'h0, h};
      default: return w;
    endcase
  endfunction

  task automatic model_write(input acc_t a);
    int base;
    if (a.alu[31:28] != 4'hB) return;
    base = int'(a.alu[9:2]) * 4;
    case (a.f3[1:0])
      2'b00: ram_b[base + int'(a.alu[1:0])] = a.rs2[7:0];
      2'b01: begin
        ram_b[base + (a.alu[1] ? 2 : 0)]     = a.rs2[7:0];
        ram_b[base + (a.alu[1] ? 2 : 0) + 1] = a.rs2[15:8];
      end
      default: for (int i = 0; i < 4; i++) ram_b[base + i] = a.rs2[8*i +: 8];
    endcase
  endtask

  task automatic clear_model();
    for (int i = 0; i < 1024; i++) ram_b[i] = 8'h00;
  endtask

  // One clock: check what the last edge produced, predict the next edge, then drive the new access.
  task automatic cycle(input acc_t a, input logic rst);
    @(negedge clk);
    check("model", data_out, exp_cur);
    if (landed.valid && landed.has_exp)
      check($sformatf("vec%0d", landed.id), data_out, landed.exp);
    if (rst) begin
      clear_model();
      exp_cur      = 32'h0;
      prev.valid   = 1'b0;
      landed.valid = 1'b0;
    end else begin
      if (prev.valid) begin
        if (prev.wr) model_write(prev);
        else         exp_cur = model_load(prev);
      end
      landed = prev;
      prev   = a;
    end
    reset     = rst;
    mem_read  = a.rd;
    mem_write = a.wr;
    func3     = a.f3;
    rs2_data  = a.rs2;
    alu_out   = a.alu;
    address   = a.addr;
  endtask

  function automatic logic [31:0] rand_addr();
    logic [3:0] region;
    case ($urandom_range(0, 3))
      0:       region = 4'hA;
      1, 2:    region = 4'hB;
      default: region = 4'hC;
    endcase
    return {region, 18'($urandom), 3'b000, 7'($urandom)};
  endfunction

  acc_t vecs [24];
  acc_t r;

  initial begin
    reset = 1'b1; mem_read = 1'b0; mem_write = 1'b0; func3 = 3'b000;
    rs2_data = 32'h0; alu_out = 32'h0; address = 32'h0;
    exp_cur = 32'h0;
    prev.valid = 1'b0; landed.valid = 1'b0;
    clear_model();

    vecs[0]  = mk(0, 0, 3'b010, 32'h0,        32'h0,         32'hA000_0004, 1, 32'hA500_0001, 0);
    vecs[1]  = mk(0, 1, 3'b010, 32'h1234_5678, 32'hB000_0002, 32'h0,        1, 32'hA500_0001, 1);
    vecs[2]  = mk(0, 1, 3'b010, 32'h1234_5678, 32'hB000_0002, 32'h0,        1, 32'hA500_0001, 2);
    vecs[3]  = mk(1, 0, 3'b010, 32'h0,        32'hB000_0002, 32'h0,         1, 32'h1234_5678, 3);
    vecs[4]  = mk(1, 0, 3'b000, 32'h0,        32'hB000_0000, 32'h0,         1, 32'h0000_0078, 4);
    vecs[5]  = mk(0, 1, 3'b000, 32'h0000_00F0, 32'hB000_0001, 32'h0,        1, 32'h0000_0078, 5);
    vecs[6]  = mk(1, 0, 3'b000, 32'h0,        32'hB000_0001, 32'h0,         1, 32'hFFFF_FFF0, 6);
    vecs[7]  = mk(1, 0, 3'b100, 32'h0,        32'hB000_0001, 32'h0,         1, 32'h0000_00F0, 7);
    vecs[8]  = mk(1, 0, 3'b010, 32'h0,        32'hC000_0000, 32'h0,         1, 32'h0000_0000, 8);
    vecs[9]  = mk(0, 1, 3'b010, 32'hDEAD_BEEF, 32'hA000_0000, 32'h0,        1, 32'h0000_0000, 9);
    vecs[10] = mk(0, 0, 3'b010, 32'h0,        32'h0,         32'hA000_0000, 1, 32'hA500_0000, 10);
    vecs[11] = mk(1, 0, 3'b001, 32'h0,        32'hB000_0002, 32'h0,         1, 32'h0000_1234, 11);
    vecs[12] = mk(1, 0, 3'b001, 32'h0,        32'hB000_0000, 32'h0,         1, 32'hFFFF_F078, 12);
    vecs[13] = mk(1, 0, 3'b101, 32'h0,        32'hB000_0000, 32'h0,         1, 32'h0000_F078, 13);
    vecs[14] = mk(0, 1, 3'b001, 32'h5555_ABCD, 32'hB000_0006, 32'h0,        1, 32'h0000_F078, 14);
    vecs[15] = mk(1, 0, 3'b010, 32'h0,        32'hB000_0004, 32'h0,         1, 32'hABCD_0000, 15);
    vecs[16] = mk(1, 0, 3'b011, 32'h0,        32'hB000_0004, 32'h0,         1, 32'hABCD_0000, 16);
    vecs[17] = mk(0, 0, 3'b000, 32'h0,        32'hB000_0000, 32'hB000_0004, 1, 32'hABCD_0000, 17);
    vecs[18] = mk(1, 1, 3'b010, 32'hCAFE_F00D, 32'hB000_0008, 32'h0,        1, 32'hABCD_0000, 18);
    vecs[19] = mk(1, 0, 3'b010, 32'h0,        32'hB000_0008, 32'h0,         1, 32'hCAFE_F00D, 19);
    vecs[20] = mk(1, 0, 3'b000, 32'h0,        32'hB000_0003, 32'h0,         1, 32'h0000_0012, 20);
    vecs[21] = mk(0, 1, 3'b000, 32'h0000_0080, 32'hB000_0003, 32'h0,        1, 32'h0000_0012, 21);
    vecs[22] = mk(1, 0, 3'b000, 32'h0,        32'hB000_0003, 32'h0,         1, 32'hFFFF_FF80, 22);
    vecs[23] = mk(0, 0, 3'b010, 32'h0,        32'h0,         32'hA000_03FC, 1, 32'hA500_00FF, 23);

    // Reset for one edge, then idle fetches from address 0 keep data_out at 0.
    cycle(fetch(32'h0), 1'b1);
    cycle(fetch(32'h0), 1'b0);
    cycle(fetch(32'h0), 1'b0);
    cycle(fetch(32'h0), 1'b0);

    for (int i = 0; i < 24; i++) cycle(vecs[i], 1'b0);
    cycle(fetch(32'h0), 1'b0);
    cycle(fetch(32'h0), 1'b0);

    // RAM is cleared by reset, and the ROM still answers afterwards.
    cycle(mk(0, 1, 3'b010, 32'hDEAD_BEEF, 32'hB000_0010, 32'h0, 0, 32'h0, -1), 1'b0);
    cycle(mk(1, 0, 3'b010, 32'h0, 32'hB000_0010, 32'h0, 1, 32'hDEAD_BEEF, 100), 1'b0);
    cycle(fetch(32'h0), 1'b0);
    cycle(fetch(32'h0), 1'b0);
    cycle(fetch(32'h0), 1'b1);
    cycle(mk(1, 0, 3'b010, 32'h0, 32'hB000_0010, 32'h0, 1, 32'h0, 101), 1'b0);
    cycle(mk(1, 0, 3'b010, 32'h0, 32'hB000_0004, 32'h0, 1, 32'h0, 102), 1'b0);
    cycle(fetch(32'hA000_0004), 1'b0);
    cycle(mk(1, 0, 3'b010, 32'h0, 32'hA000_0004, 32'h0, 1, 32'hA500_0001, 103), 1'b0);
    cycle(fetch(32'h0), 1'b0);
    cycle(fetch(32'h0), 1'b0);

    for (int n = 0; n < 400; n++) begin
      r = fetch(rand_addr());
      r.alu = rand_addr();
      r.rs2 = $urandom;
      case ($urandom_range(0, 3))
        0: ;
        1: begin r.rd = 1'b1; r.f3 = 3'($urandom_range(0, 7)); end
        2: begin r.wr = 1'b1; r.f3 = 3'($urandom_range(0, 2)); end
        default: begin r.rd = 1'b1; r.wr = 1'b1; r.f3 = 3'($urandom_range(0, 2)); end
      endcase
      cycle(r, 1'b0);
    end
    cycle(fetch(32'h0), 1'b0);
    cycle(fetch(32'h0), 1'b0);
    cycle(fetch(32'h0), 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
